gate_sweep_checker: RTL and testbench

- Sequential stimulus-and-check block that sits on the opposite side of a 2-input logic-gate unit (AND, OR, NOT-a, NAND, NOR, XOR, XNOR).
- Drives the gate unit's inputs a and b through all four combinations (00, 01, 10, 11).
- After a programmable settle time, samples the unit's seven outputs and compares each one against a golden model.
- Accumulates per-gate sticky failure flags and an error count, then reports pass/fail with a one-cycle done pulse. Used as a self-test engine at bring-up and in the team's gate-level benches.

---
 rtl/gate_chk_pkg.sv | 28 ++
 rtl/gate_sweep_checker_golden.sv | 14 +
 rtl/gate_sweep_checker.sv | 140 ++++++++++++++
 tb/tb_gate_sweep_checker.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types, gate bit positions and golden truth function for the gate sweep checker.
package gate_chk_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_e;

  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_NOT  = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XOR  = 5;
  localparam int GATE_XNOR = 6;
  localparam int NUM_GATES = 7;

  function automatic logic [NUM_GATES-1:0] expected_gates(input logic a, input logic b);
    logic [NUM_GATES-1:0] e;
    e            = '0;
    e[GATE_AND]  = a & b;
    e[GATE_OR]   = a | b;
    e[GATE_NOT]  = ~a;
    e[GATE_NAND] = ~(a & b);
    e[GATE_NOR]  = ~(a | b);
    e[GATE_XOR]  = a ^ b;
    e[GATE_XNOR] = ~(a ^ b);
    return e;
  endfunction

endpackage

// File: rtl/gate_sweep_checker_golden.sv
// Combinational golden model of the 2-input gate unit; no state, zero latency.
module gate_golden
  import gate_chk_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] expected
);

  always_comb begin
    expected = expected_gates(a, b);
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Sweeps (a,b) through 00,01,10,11, checks the gate unit after SETTLE_CYCLES per combo,
// and reports sticky per-gate failures, a saturating error count, pass and a done pulse.
module gate_sweep_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_GATES-1:0] gates_i,
  output logic                 a_o,
  output logic                 b_o,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [NUM_GATES-1:0] fail_vec
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SUM_W = ((ERR_W > 3) ? ERR_W : 3) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [SUM_W-1:0] ERR_MAX  = SUM_W'((2 ** ERR_W) - 1);

  state_e               state_q, state_d;
  logic [1:0]           combo_q, combo_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic [NUM_GATES-1:0] fail_q, fail_d;

  logic [NUM_GATES-1:0] expected;
  logic [NUM_GATES-1:0] mismatch;
  logic [2:0]           pop;
  logic [SUM_W-1:0]     err_sum;
  logic [ERR_W-1:0]     err_sat;

  gate_golden u_golden (
    .a        (combo_q[1]),
    .b        (combo_q[0]),
    .expected (expected)
  );

  // Mismatch math runs every cycle but only CHECK consumes it, so X on gates_i elsewhere is harmless.
  always_comb begin
    mismatch = gates_i ^ expected;
    pop      = 3'd0;
    for (int i = 0; i < NUM_GATES; i++) begin
      pop = pop + {2'b00, mismatch[i]};
    end
    err_sum = SUM_W'(err_q) + SUM_W'(pop);
    err_sat = (err_sum > ERR_MAX) ? ERR_MAX[ERR_W-1:0] : err_sum[ERR_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    combo_d = combo_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          combo_d = 2'd0;
          cnt_d   = CNT_LOAD;
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CHECK: begin
        fail_d = fail_q | mismatch;
        err_d  = err_sat;
        if (combo_q == 2'd3) begin
          // done and pass rise together so pass already reflects the final combo.
          done_d  = 1'b1;
          pass_d  = (err_sat == '0);
          state_d = DONE;
        end else begin
          combo_d = combo_q + 2'd1;
          cnt_d   = CNT_LOAD;
          state_d = SETTLE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        combo_d = 2'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      combo_q <= 2'd0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      combo_q <= combo_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign a_o       = combo_q[1];
  assign b_o       = combo_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench: two checker instances (settle 1 and 3) facing a bench-modelled gate unit with injectable faults.
module tb_gate_sweep_checker;
  import gate_chk_pkg::*;

  typedef struct {
    logic       pass;
    logic [4:0] err;
    logic [6:0] fail;
  } res_t;

  res_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1, start0, start1;
  logic [6:0] gates0, gates1;
  logic       a0, b0, busy0, done0, pass0;
  logic       a1, b1, busy1, done1, pass1;
  logic [4:0] err0, err1;
  logic [6:0] fail0, fail1;

  int   mode;
  bit   sel;
  logic cur_a, cur_b, cur_busy, cur_done, cur_pass;
  logic [4:0] cur_err;
  logic [6:0] cur_fail;

  gate_sweep_checker #(.SETTLE_CYCLES(1), .ERR_W(5)) u_s1 (
    .clk(clk), .rst(rst0), .start(start0), .gates_i(gates0),
    .a_o(a0), .b_o(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_vec(fail0)
  );

  gate_sweep_checker #(.SETTLE_CYCLES(3), .ERR_W(5)) u_s3 (
    .clk(clk), .rst(rst1), .start(start1), .gates_i(gates1),
    .a_o(a1), .b_o(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fail1)
  );

  // Gate unit under test: 0 correct, 1 xor stuck-at-0, 2 nand wired to and, 3 all outputs 0.
  function automatic logic [6:0] unit(input logic a, input logic b, input int m);
    logic [6:0] g;
    g = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    case (m)
      1: g[5] = 1'b0;
      2: g[3] = a & b;
      3: g = 7'h00;
      default: ;
    endcase
    return g;
  endfunction

  always_comb begin
    gates0   = unit(a0, b0, mode);
    gates1   = unit(a1, b1, mode);
    cur_a    = sel ? a1 : a0;
    cur_b    = sel ? b1 : b0;
    cur_busy = sel ? busy1 : busy0;
    cur_done = sel ? done1 : done0;
    cur_pass = sel ? pass1 : pass0;
    cur_err  = sel ? err1 : err0;
    cur_fail = sel ? fail1 : fail0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_start(input logic v);
    if (sel) start1 = v;
    else start0 = v;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_a"}, 32'(cur_a), 32'd0);
    chk({tag, "_b"}, 32'(cur_b), 32'd0);
    chk({tag, "_busy"}, 32'(cur_busy), 32'd0);
    chk({tag, "_done"}, 32'(cur_done), 32'd0);
    chk({tag, "_pass"}, 32'(cur_pass), 32'd0);
    chk({tag, "_err"}, 32'(cur_err), 32'd0);
    chk({tag, "_fail"}, 32'(cur_fail), 32'd0);
  endtask

  // One full sweep on the selected instance; start is sampled high on edges 0..start_len-1.
  task automatic sweep(input string tag, input int s, input int start_len,
                       input logic e_pass, input logic [4:0] e_err, input logic [6:0] e_fail);
    int   total;
    res_t r, got;
    total  = 4 * (s + 1);
    r.pass = e_pass;
    r.err  = e_err;
    r.fail = e_fail;
    sb.push_back(r);
    @(negedge clk);
    set_start(1'b1);
    for (int k = 0; k <= total + 2; k++) begin
      @(posedge clk);
      #1;
      if (k >= start_len - 1) set_start(1'b0);
      if (k == 0) begin
        chk({tag, "_busy_acc"}, 32'(cur_busy), 32'd1);
        chk({tag, "_err_clr"}, 32'(cur_err), 32'd0);
        chk({tag, "_fail_clr"}, 32'(cur_fail), 32'd0);
      end
      if (k < total) begin
        chk({tag, "_ab"}, 32'({cur_a, cur_b}), 32'(k / (s + 1)));
        chk({tag, "_done_early"}, 32'(cur_done), 32'd0);
      end else if (k == total) begin
        chk({tag, "_done"}, 32'(cur_done), 32'd1);
        chk({tag, "_busy_done"}, 32'(cur_busy), 32'd1);
        if (sb.size() == 0) begin
          chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
          got = sb.pop_front();
          chk({tag, "_pass"}, 32'(cur_pass), 32'(got.pass));
          chk({tag, "_err"}, 32'(cur_err), 32'(got.err));
          chk({tag, "_fail"}, 32'(cur_fail), 32'(got.fail));
        end
      end else if (k == total + 1) begin
        chk({tag, "_done_fall"}, 32'(cur_done), 32'd0);
        chk({tag, "_busy_fall"}, 32'(cur_busy), 32'd0);
        chk({tag, "_ab_idle"}, 32'({cur_a, cur_b}), 32'd0);
      end else begin
        chk({tag, "_no_restart"}, 32'(cur_busy), 32'd0);
        chk({tag, "_pass_hold"}, 32'(cur_pass), 32'(e_pass));
        chk({tag, "_err_hold"}, 32'(cur_err), 32'(e_err));
      end
    end
  endtask

  initial begin
    mode   = 0;
    sel    = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    rst0   = 1'b1;
    rst1   = 1'b1;
    repeat (3) @(negedge clk);
    rst0 = 1'b0;
    rst1 = 1'b0;
    @(posedge clk);
    #1;
    sel = 1'b0;
    #1;
    check_reset_outputs("rst_s1");
    sel = 1'b1;
    #1;
    check_reset_outputs("rst_s3");

    sel  = 1'b0;
    mode = 0;
    sweep("good_s1", 1, 1, 1'b1, 5'd0, 7'h00);
    mode = 1;
    sweep("xor_sa0", 1, 1, 1'b0, 5'd2, 7'b0100000);
    mode = 2;
    sweep("nand_as_and", 1, 1, 1'b0, 5'd4, 7'b0001000);
    mode = 3;
    sweep("all_zero", 1, 1, 1'b0, 5'd14, 7'h7F);
    mode = 0;
    sweep("good_again", 1, 1, 1'b1, 5'd0, 7'h00);

    sel = 1'b1;
    // start held through the DONE cycle (edges 0..17) must yield one sweep only.
    sweep("held_start", 3, 18, 1'b1, 5'd0, 7'h00);
    repeat (2) @(negedge clk);
    sweep("restart", 3, 1, 1'b1, 5'd0, 7'h00);

    // Abort during the third SETTLE (combo 2, edges 8..10) with partial errors accumulated.
    mode = 3;
    @(negedge clk);
    set_start(1'b1);
    for (int k = 0; k <= 9; k++) begin
      @(posedge clk);
      #1;
      set_start(1'b0);
    end
    chk("abort_err_before", 32'(cur_err), 32'd8);
    chk("abort_ab_before", 32'({cur_a, cur_b}), 32'd2);
    rst1 = 1'b1;
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    check_reset_outputs("abort_rst");
    chk("abort_state", 32'(u_s3.state_q), 32'(IDLE));
    mode = 0;
    sweep("after_abort", 3, 1, 1'b1, 5'd0, 7'h00);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
